// File: rtl/audio_burst_reader.sv
// audio_burst_reader: Avalon-MM burst read master that streams a word range
// from sample storage through a show-ahead FIFO onto a valid/ready stream.
// Supports one-shot and looped playback plus abort.
module audio_burst_reader #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 32,
    parameter int BURST_MAX  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    input  logic [ADDR_W-1:0]             start_addr,
    input  logic [ADDR_W-1:0]             num_words,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W-1:0]             avm_address,
    output logic                          avm_read,
    output logic [3:0]                    avm_burstcount,
    input  logic [DATA_W-1:0]             avm_readdata,
    input  logic                          avm_waitrequest,
    input  logic                          avm_readdatavalid,
    output logic [DATA_W-1:0]             sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN, S_FLUSH} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cur_addr, r_remaining, r_base_addr, r_base_num;
    logic [3:0]          r_beats_left;
    logic                r_busy, r_done;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr, r_rptr;
    logic [LW-1:0]       r_count;

    logic [3:0]          w_blen;
    logic [LW-1:0]       w_free;
    logic                w_start_ok, w_zero_start, w_accept, w_last_beat, w_reload;
    logic                w_push, w_pop, w_clear;

    assign w_blen       = (r_remaining >= ADDR_W'(BURST_MAX)) ? 4'(BURST_MAX) : r_remaining[3:0];
    assign w_free       = LW'(FIFO_DEPTH) - r_count;
    assign w_start_ok   = (r_state == S_IDLE) && start && !r_busy;
    assign w_zero_start = w_start_ok && (num_words == '0);
    assign w_accept     = avm_read && !avm_waitrequest;
    assign w_last_beat  = avm_readdatavalid && (r_beats_left == 4'd1);
    assign w_reload     = (r_state == S_DATA) && !stop && w_last_beat &&
                          (r_remaining == '0) && loop_en;

    // Output pops are suppressed while flushing so the sink never sees stale words.
    assign sample_valid   = (r_count != '0) && (r_state != S_FLUSH);
    assign sample_data    = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign w_pop          = sample_valid && sample_ready;
    assign fifo_level     = r_count;
    assign busy           = r_busy;
    assign done           = r_done;
    assign avm_address    = r_cur_addr;
    assign avm_burstcount = w_blen;

    // FSM state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_IDLE;
        else                r_state <= w_state_nxt;
    end

    // Next state, read request, FIFO push/clear strobes
    always_comb begin
        w_state_nxt = r_state;
        avm_read    = 1'b0;
        w_push      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok && (num_words != '0)) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (stop) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    // free space only grows in REQ, so once raised the request stays up
                    avm_read = (LW'(w_blen) <= w_free);
                    if (avm_read && !avm_waitrequest) w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (stop) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_push = avm_readdatavalid;
                    if (w_last_beat)
                        w_state_nxt = ((r_remaining != '0) || loop_en) ? S_REQ : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_count == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if ((r_beats_left == '0) || w_last_beat) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // busy covers start..IDLE; a zero-length start gives a one-cycle busy with done
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE) || w_zero_start;
            r_done <= w_zero_start || ((r_state == S_DRAIN) && !stop && (r_count == '0));
        end
    end

    // Address/length bookkeeping and per-burst beat counter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_base_addr  <= '0;
            r_base_num   <= '0;
            r_beats_left <= '0;
        end else begin
            if (w_start_ok) begin
                r_cur_addr  <= start_addr;
                r_remaining <= num_words;
                r_base_addr <= start_addr;
                r_base_num  <= num_words;
            end
            if (w_accept) begin
                r_cur_addr   <= r_cur_addr + ADDR_W'(w_blen);
                r_remaining  <= r_remaining - ADDR_W'(w_blen);
                r_beats_left <= w_blen;
            end else if (((r_state == S_DATA) || (r_state == S_FLUSH)) &&
                         avm_readdatavalid && (r_beats_left != '0)) begin
                r_beats_left <= r_beats_left - 4'd1;
            end
            if (w_reload) begin
                r_cur_addr  <= r_base_addr;
                r_remaining <= r_base_num;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + LW'(w_push) - LW'(w_pop);
        end
    end

    // FIFO storage (no reset; unread entries are masked at the output)
    always_ff @(posedge clk_clk) begin
        if (w_push) r_mem[r_wptr] <= avm_readdata;
    end
endmodule

// File: tb/tb_audio_burst_reader.sv
// Directed bench for audio_burst_reader: table-driven playback vectors plus
// hand-written sequences for backpressure, looping, stop, zero length, reset.
module tb_audio_burst_reader;
    localparam int ADDR_W = 19, DATA_W = 32, BURST_MAX = 8, FIFO_DEPTH = 16;

    logic              clk_clk = 1'b0, reset_reset_n = 1'b0;
    logic              start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0, num_words = '0;
    logic              busy, done, avm_read;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_burstcount;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready = 1'b1;
    logic [4:0]        fifo_level;

    audio_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX),
                         .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start), .stop(stop),
        .loop_en(loop_en), .start_addr(start_addr), .num_words(num_words),
        .busy(busy), .done(done), .avm_address(avm_address), .avm_read(avm_read),
        .avm_burstcount(avm_burstcount), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .fifo_level(fifo_level));

    always #5 clk_clk = ~clk_clk;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return 32'h5A00_0000 | {13'h0, a};
    endfunction

    typedef struct { logic [ADDR_W-1:0] addr; logic [3:0] bc; } burst_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [ADDR_W-1:0] n; int waitc; int bursts; } vec_t;

    burst_t            pend_q[$];
    burst_t            acc_log[$];
    logic [DATA_W-1:0] rx_q[$];
    int  n_beats = 0, n_done = 0, stab_viol = 0, space_viol = 0, ovf = 0;
    int  wait_cfg = 0;
    int  n_pass = 0, n_total = 0;
    logic              hold_chk = 1'b0;
    logic [ADDR_W-1:0] hold_addr = '0;
    logic [3:0]        hold_bc = '0;

    // Monitor: bursts accepted, beats, done pulses, sink pops, protocol rules
    always @(posedge clk_clk) begin
        if (avm_read && !avm_waitrequest) begin
            pend_q.push_back('{addr: avm_address, bc: avm_burstcount});
            acc_log.push_back('{addr: avm_address, bc: avm_burstcount});
        end
        if (avm_readdatavalid) n_beats <= n_beats + 1;
        if (done) n_done <= n_done + 1;
        if (sample_valid && sample_ready) rx_q.push_back(sample_data);
        if (hold_chk && (!avm_read || avm_address != hold_addr || avm_burstcount != hold_bc))
            stab_viol <= stab_viol + 1;
        hold_chk  <= avm_read && avm_waitrequest;
        hold_addr <= avm_address;
        hold_bc   <= avm_burstcount;
        if (avm_read && (FIFO_DEPTH - int'(fifo_level)) < int'(avm_burstcount))
            space_viol <= space_viol + 1;
        if (dut.w_push && dut.r_count == 5'(FIFO_DEPTH)) ovf <= ovf + 1;
    end

    // Slave: waitrequest per request, then one beat per cycle for each accepted burst
    int                b_left = 0, wr_cnt = 0;
    bit                req_seen = 0;
    logic [ADDR_W-1:0] b_addr = '0;
    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            pend_q.delete();
            b_left = 0; wr_cnt = 0; req_seen = 0;
            avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
        end else begin
            if (avm_readdatavalid) begin b_left--; b_addr++; end
            if (b_left == 0 && pend_q.size() > 0) begin
                b_addr = pend_q[0].addr; b_left = int'(pend_q[0].bc);
                pend_q.delete(0);
            end
            avm_readdatavalid = (b_left > 0);
            avm_readdata      = (b_left > 0) ? word_of(b_addr) : '0;
            if (!avm_read) begin
                req_seen = 0; avm_waitrequest = 1'b0;
            end else begin
                if (!req_seen) begin req_seen = 1; wr_cnt = wait_cfg; end
                avm_waitrequest = (wr_cnt > 0);
                if (wr_cnt > 0) wr_cnt--;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] n, input logic lp);
        start_addr = a; num_words = n; loop_en = lp; start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        int base = n_done;
        ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk_clk);
            if (n_done != base) ok = 1;
        end
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk_clk);
            if (!busy) ok = 1;
        end
    endtask

    task automatic check_stream(input string nm, input logic [ADDR_W-1:0] a, input int n);
        int bad = 0;
        chk({nm, "_count"}, rx_q.size(), n);
        for (int j = 0; j < rx_q.size() && j < n; j++)
            if (rx_q[j] !== word_of(a + ADDR_W'(j))) bad++;
        chk({nm, "_data_bad"}, bad, 0);
    endtask

    vec_t vecs[5];

    initial begin
        bit ok;
        int base_done, nb0, bad;
        logic [ADDR_W-1:0] ea;
        int rem;

        vecs[0] = '{19'h00100, 19'd20, 0, 3};
        vecs[1] = '{19'h00200, 19'd20, 3, 3};
        vecs[2] = '{19'h7FFFC, 19'd9,  1, 2};
        vecs[3] = '{19'h00000, 19'd8,  0, 1};
        vecs[4] = '{19'h00010, 19'd1,  2, 1};

        // reset state
        #2;
        chk("rst_ctrl", {busy, done, avm_read, sample_valid}, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_bc", avm_burstcount, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_data", sample_data, 0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (2) @(negedge clk_clk);

        // table-driven playback runs
        foreach (vecs[i]) begin
            wait_cfg = vecs[i].waitc; sample_ready = 1'b1;
            acc_log.delete(); rx_q.delete();
            base_done = n_done;
            do_start(vecs[i].addr, vecs[i].n, 1'b0);
            wait_done(500, ok);
            repeat (3) @(negedge clk_clk);
            chk($sformatf("v%0d_done_seen", i), ok, 1);
            chk($sformatf("v%0d_bursts", i), acc_log.size(), vecs[i].bursts);
            rem = int'(vecs[i].n);
            for (int k = 0; k < acc_log.size() && k < vecs[i].bursts; k++) begin
                ea = vecs[i].addr + ADDR_W'(8 * k);
                chk($sformatf("v%0d_burst%0d", i, k), {acc_log[k].addr, acc_log[k].bc},
                    {ea, 4'((rem > 8) ? 8 : rem)});
                rem -= 8;
            end
            check_stream($sformatf("v%0d", i), vecs[i].addr, int'(vecs[i].n));
            chk($sformatf("v%0d_done_once", i), n_done - base_done, 1);
            chk($sformatf("v%0d_busy_low", i), busy, 0);
        end

        // zero-length start
        acc_log.delete(); base_done = n_done;
        do_start(19'h00123, 19'd0, 1'b0);
        chk("zero_busy_hi", busy, 1);
        chk("zero_done_hi", done, 1);
        @(negedge clk_clk);
        chk("zero_after", {busy, done}, 0);
        repeat (4) @(negedge clk_clk);
        chk("zero_no_read", acc_log.size(), 0);
        chk("zero_done_once", n_done - base_done, 1);

        // backpressure: sink stalled, FIFO fills and requests stop
        wait_cfg = 0; sample_ready = 1'b0;
        acc_log.delete(); rx_q.delete(); base_done = n_done;
        do_start(19'h00300, 19'd40, 1'b0);
        repeat (60) @(negedge clk_clk);
        chk("bp_level_full", fifo_level, 16);
        chk("bp_bursts_held", acc_log.size(), 2);
        chk("bp_no_read", avm_read, 0);
        do_start(19'h00000, 19'd0, 1'b0);   // ignored while busy
        sample_ready = 1'b1;
        wait_done(600, ok);
        repeat (3) @(negedge clk_clk);
        chk("bp_done_seen", ok, 1);
        check_stream("bp", 19'h00300, 40);
        chk("bp_bursts_total", acc_log.size(), 5);
        chk("bp_done_once", n_done - base_done, 1);

        // looped playback across the address wrap
        acc_log.delete(); rx_q.delete(); base_done = n_done;
        do_start(19'h7FFFE, 19'd5, 1'b1);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk_clk);
            if (rx_q.size() >= 12) ok = 1;
        end
        chk("loop_progress", ok, 1);
        bad = 0;
        for (int j = 0; j < 12 && j < rx_q.size(); j++)
            if (rx_q[j] !== word_of(19'h7FFFE + ADDR_W'(j % 5))) bad++;
        chk("loop_data_bad", bad, 0);
        if (acc_log.size() >= 2) begin
            chk("loop_burst0", {acc_log[0].addr, acc_log[0].bc}, {19'h7FFFE, 4'd5});
            chk("loop_burst1", {acc_log[1].addr, acc_log[1].bc}, {19'h7FFFE, 4'd5});
        end else chk("loop_burst_count", acc_log.size(), 2);
        chk("loop_no_done", n_done - base_done, 0);
        stop = 1'b1; @(negedge clk_clk); stop = 1'b0; loop_en = 1'b0;
        wait_idle(100, ok);
        chk("loop_stop_idle", ok, 1);
        @(negedge clk_clk);
        chk("loop_stop_valid", sample_valid, 0);
        chk("loop_stop_no_done", n_done - base_done, 0);

        // stop after two beats of an eight-beat burst
        acc_log.delete(); rx_q.delete(); base_done = n_done; nb0 = n_beats;
        do_start(19'h00400, 19'd16, 1'b0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (n_beats - nb0 == 2) ok = 1;
            else @(negedge clk_clk);
        end
        chk("stop_reach_2beats", ok, 1);
        stop = 1'b1; @(negedge clk_clk); stop = 1'b0;
        wait_idle(50, ok);
        chk("stop_idle", ok, 1);
        @(negedge clk_clk);
        chk("stop_beats_drained", n_beats - nb0, 8);
        check_stream("stop", 19'h00400, 2);
        chk("stop_valid_low", sample_valid, 0);
        chk("stop_level", fifo_level, 0);
        chk("stop_no_done", n_done - base_done, 0);
        rx_q.delete(); base_done = n_done;
        do_start(19'h00500, 19'd3, 1'b0);
        wait_done(200, ok);
        repeat (2) @(negedge clk_clk);
        chk("restart_done", ok, 1);
        check_stream("restart", 19'h00500, 3);

        // asynchronous reset mid-burst
        sample_ready = 1'b0; nb0 = n_beats;
        do_start(19'h00600, 19'd16, 1'b0);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_clk);
            if (n_beats - nb0 >= 3) ok = 1;
        end
        chk("rstmid_reach", ok, 1);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("rstmid_ctrl", {busy, done, avm_read, sample_valid}, 0);
        chk("rstmid_addr", {avm_address, avm_burstcount}, 0);
        chk("rstmid_level", fifo_level, 0);
        chk("rstmid_data", sample_data, 0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1; sample_ready = 1'b1;
        repeat (3) @(negedge clk_clk);
        chk("rstmid_idle", {busy, avm_read, sample_valid}, 0);

        chk("no_overflow", ovf, 0);
        chk("space_rule", space_viol, 0);
        chk("wait_stable", stab_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
